csa_accum_ctrl: RTL and testbench

//  Sequencer for multi-operand addition using a 3:2 carry-save stage.

---
 rtl/csa_pkg.sv | 18 +
 rtl/csa_accum_ctrl_if.sv | 27 ++
 rtl/csa_stage.sv | 15 +
 rtl/csa_accum_ctrl.sv | 108 ++++++++++
 tb/tb_csa_accum_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_MAX_OPS = 8;

  function automatic int out_width(int w, int n);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// Operand stream in, resolved total out.
interface csa_accum_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int OUT_W = 11
);

  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic             op_valid;
  logic [WIDTH-1:0] op_data;
  logic             op_ready;
  logic             busy;
  logic [OUT_W-1:0] result;
  logic             result_valid;

  modport master (
    output start, num_ops, op_valid, op_data,
    input  op_ready, busy, result, result_valid
  );

  modport slave (
    input  start, num_ops, op_valid, op_data,
    output op_ready, busy, result, result_valid
  );

endinterface

// File: rtl/csa_stage.sv
// 3:2 compressor; carry is returned unshifted.
module csa_stage #(
  parameter int W = 11
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand adder: redundant sum/carry accumulation,
// one carry-propagate add at the end.
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_OPS = DEF_MAX_OPS,
  parameter int CNT_W   = $clog2(MAX_OPS + 1),
  parameter int OUT_W   = out_width(WIDTH, MAX_OPS)
) (
  input logic clk,
  input logic rst,
  csa_accum_ctrl_if.slave bus
);

  state_t state, state_nx;

  logic [CNT_W-1:0] n_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] n_clamp;
  logic [OUT_W-1:0] sum_r;
  logic [OUT_W-1:0] carry_r;
  logic [OUT_W-1:0] result_r;
  logic [OUT_W-1:0] x;
  logic [OUT_W-1:0] s;
  logic [OUT_W-1:0] c;
  logic             ready;
  logic             rvalid;
  logic             acc;

  assign x       = OUT_W'(bus.op_data);
  assign cnt_inc = cnt + 1'b1;
  assign acc     = bus.op_valid & ready;
  assign n_clamp = (bus.num_ops > CNT_W'(MAX_OPS))
                 ? CNT_W'(MAX_OPS) : bus.num_ops;

  csa_stage #(.W(OUT_W)) u_stage (
    .x (sum_r),
    .y (carry_r),
    .z (x),
    .s (s),
    .c (c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_r      <= '0;
      cnt      <= '0;
      sum_r    <= '0;
      carry_r  <= '0;
      result_r <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            n_r     <= n_clamp;
            cnt     <= '0;
            sum_r   <= '0;
            carry_r <= '0;
          end
        end
        ACCUM: begin
          if (acc) begin
            sum_r   <= s;
            carry_r <= c << 1;
            cnt     <= cnt_inc;
          end
        end
        // Carry-out is impossible given OUT_W sizing.
        RESOLVE: result_r <= sum_r + carry_r;
        DONE: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    rvalid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start)
          state_nx = (n_clamp == '0) ? RESOLVE : ACCUM;
      end
      ACCUM: begin
        ready = 1'b1;
        if (acc && cnt_inc == n_r)
          state_nx = RESOLVE;
      end
      RESOLVE: state_nx = DONE;
      DONE: begin
        rvalid   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.op_ready     = ready;
  assign bus.busy         = (state != IDLE);
  assign bus.result       = result_r;
  assign bus.result_valid = rvalid;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl.
module tb_csa_accum_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rdy_seen;

  csa_accum_ctrl_if #(.WIDTH(8), .CNT_W(4), .OUT_W(11)) bus ();

  csa_accum_ctrl #(.WIDTH(8), .MAX_OPS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(logic [3:0] n);
    bus.start   = 1'b1;
    bus.num_ops = n;
    tick();
    bus.start   = 1'b0;
    rdy_seen    = 0;
  endtask

  task automatic send(logic [7:0] d, int gap);
    for (int i = 0; i < gap; i++) begin
      bus.op_valid = 1'b0;
      chk("bubble_ready", 32'(bus.op_ready), 32'd1);
      tick();
    end
    bus.op_valid = 1'b1;
    bus.op_data  = d;
    if (bus.op_ready) rdy_seen++;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic finish_job(string tag, logic [10:0] exp);
    chk({tag, "_res_rv0"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_res_rdy0"}, 32'(bus.op_ready), 32'd0);
    chk({tag, "_res_busy"}, 32'(bus.busy), 32'd1);
    tick();
    chk({tag, "_done_rv"}, 32'(bus.result_valid), 32'd1);
    chk({tag, "_result"}, 32'(bus.result), 32'(exp));
    tick();
    chk({tag, "_idle_rv0"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_idle_busy0"}, 32'(bus.busy), 32'd0);
    chk({tag, "_held"}, 32'(bus.result), 32'(exp));
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.num_ops  = '0;
    bus.op_valid = 1'b0;
    bus.op_data  = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.op_ready), 32'd0);
    chk("rst_rv", 32'(bus.result_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    rst = 1'b0;
    tick();

    // 1: three 0xFF back-to-back
    do_start(4'd3);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    finish_job("t1", 11'h2FD);

    // 2: eight 0xFF, maximal total
    do_start(4'd8);
    for (int i = 0; i < 8; i++) send(8'hFF, 0);
    chk("t2_ready_cycles", 32'(rdy_seen), 32'd8);
    finish_job("t2", 11'h7F8);

    // 3: bubbles between operands
    do_start(4'd4);
    chk("t3_hold_prev", 32'(bus.result), 32'h7F8);
    send(8'd1, 0);
    send(8'd2, 1);
    send(8'd3, 2);
    send(8'd4, 3);
    finish_job("t3", 11'd10);

    // 4: empty job
    do_start(4'd0);
    chk("t4_result_old", 32'(bus.result), 32'd10);
    finish_job("t4", 11'd0);

    // 5: start ignored mid-job
    do_start(4'd2);
    send(8'h10, 0);
    bus.start   = 1'b1;
    bus.num_ops = 4'd5;
    tick();
    bus.start   = 1'b0;
    chk("t5_still_busy", 32'(bus.busy), 32'd1);
    send(8'h20, 0);
    finish_job("t5", 11'h030);

    // clamp: 15 requested, 8 accepted
    do_start(4'd15);
    for (int i = 0; i < 8; i++) send(8'd1, 0);
    finish_job("clamp", 11'd8);

    // 6: reset mid-job, then start+op_valid together
    do_start(4'd5);
    send(8'd1, 0);
    send(8'd2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ready", 32'(bus.op_ready), 32'd0);
    chk("t6_rv", 32'(bus.result_valid), 32'd0);
    chk("t6_result", 32'(bus.result), 32'd0);
    bus.op_valid = 1'b1;
    bus.op_data  = 8'h55;
    do_start(4'd1);
    bus.op_valid = 1'b0;
    chk("t6_accum_ready", 32'(bus.op_ready), 32'd1);
    send(8'h07, 0);
    finish_job("t6", 11'h007);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
